// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter with a per-register pending-write scoreboard.
// Two writeback requesters (A = ALU, B = memory load) share one write port;
// the accepted request is registered and presented to the register file one
// cycle later. The scoreboard tracks destinations claimed at issue and flags
// read-after-write hazards on the two read addresses.
module regfile_write_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_register,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_register,
  input  logic [DATA_W-1:0] b_data,
  input  logic              reserve_valid,
  input  logic [4:0]        reserve_register,
  input  logic [4:0]        read_register_1,
  input  logic [4:0]        read_register_2,
  output logic              hazard_1,
  output logic              hazard_2,
  output logic [31:0]       busy,
  output logic              RegWrite,
  output logic [4:0]        write_register,
  output logic [DATA_W-1:0] write_data
);

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic              last_grant_q, last_grant_d;
  logic [31:0]       busy_q, busy_d;
  logic              reg_write_q, reg_write_d;
  logic [4:0]        wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              grant_a, grant_b;
  logic [4:0]        sel_register;
  logic [DATA_W-1:0] sel_data;

  // Arbitration: single grant per cycle; under contention either alternate
  // away from the previous winner or let A win outright. Nothing is accepted
  // while reset is held, so requests presented then are simply dropped.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (a_valid && b_valid) begin
        if ((ROUND_ROBIN != 0) && (last_grant_q == GRANT_A)) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else if (a_valid) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign sel_register = grant_b ? b_register : a_register;
  assign sel_data     = grant_b ? b_data     : a_data;

  // Next state: load the write stage on a real accept, retire the scoreboard
  // bit of the written register, then apply a reservation so that a same-edge
  // claim by a newer producer keeps the register busy. Register 0 never
  // writes and is never busy.
  always_comb begin
    last_grant_d = last_grant_q;
    busy_d       = busy_q;
    reg_write_d  = 1'b0;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    if (grant_a) last_grant_d = GRANT_A;
    if (grant_b) last_grant_d = GRANT_B;
    if ((grant_a || grant_b) && (sel_register != 5'd0)) begin
      reg_write_d          = 1'b1;
      wreg_d               = sel_register;
      wdata_d              = sel_data;
      busy_d[sel_register] = 1'b0;
    end
    if (reserve_valid && (reserve_register != 5'd0)) begin
      busy_d[reserve_register] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset clears the write stage, the scoreboard, and makes
  // A the winner of the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= GRANT_B;
      busy_q       <= '0;
      reg_write_q  <= 1'b0;
      wreg_q       <= '0;
      wdata_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      reg_write_q  <= reg_write_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
    end
  end

  assign busy           = busy_q;
  assign hazard_1       = busy_q[read_register_1];
  assign hazard_2       = busy_q[read_register_2];
  assign RegWrite       = reg_write_q;
  assign write_register = wreg_q;
  assign write_data     = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: one round-robin and one fixed-priority
// instance share the same stimulus; a reference model of both is checked
// every cycle, and directed literal expectations pin the model.
module tb_regfile_write_arbiter;

  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          a_valid, b_valid, reserve_valid;
  logic [4:0]    a_register, b_register, reserve_register;
  logic [4:0]    read_register_1, read_register_2;
  logic [DW-1:0] a_data, b_data;

  logic [1:0]    a_rdy, b_rdy, haz1, haz2, rw;
  logic [31:0]   busy_w [2];
  logic [4:0]    wreg_w [2];
  logic [DW-1:0] wdata_w [2];

  int checks   = 0;
  int failures = 0;

  regfile_write_arbiter #(.ROUND_ROBIN(1), .DATA_W(DW)) dut_rr (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_rdy[0]), .a_register(a_register), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_rdy[0]), .b_register(b_register), .b_data(b_data),
    .reserve_valid(reserve_valid), .reserve_register(reserve_register),
    .read_register_1(read_register_1), .read_register_2(read_register_2),
    .hazard_1(haz1[0]), .hazard_2(haz2[0]), .busy(busy_w[0]),
    .RegWrite(rw[0]), .write_register(wreg_w[0]), .write_data(wdata_w[0])
  );

  regfile_write_arbiter #(.ROUND_ROBIN(0), .DATA_W(DW)) dut_fp (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_rdy[1]), .a_register(a_register), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_rdy[1]), .b_register(b_register), .b_data(b_data),
    .reserve_valid(reserve_valid), .reserve_register(reserve_register),
    .read_register_1(read_register_1), .read_register_2(read_register_2),
    .hazard_1(haz1[1]), .hazard_2(haz2[1]), .busy(busy_w[1]),
    .RegWrite(rw[1]), .write_register(wreg_w[1]), .write_data(wdata_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: instance 0 alternates under contention, instance 1 is A-first.
  bit            m_ok = 0;
  bit            m_last_was_a [2];
  logic [31:0]   m_busy  [2];
  bit            m_rw    [2];
  logic [4:0]    m_wreg  [2];
  logic [DW-1:0] m_wdata [2];

  function automatic bit model_take_a(int k);
    if (reset || !a_valid) return 0;
    if (!b_valid) return 1;
    if (k == 0) return !m_last_was_a[k];
    return 1;
  endfunction

  function automatic bit model_take_b(int k);
    if (reset || !b_valid) return 0;
    return !model_take_a(k);
  endfunction

  always @(negedge clk) begin
    bit ta, tb;
    logic [4:0] r;
    for (int k = 0; k < 2; k++) begin
      ta = model_take_a(k);
      tb = model_take_b(k);
      if (m_ok) begin
        chk($sformatf("a_ready[%0d]", k), a_rdy[k], ta);
        chk($sformatf("b_ready[%0d]", k), b_rdy[k], tb);
        chk($sformatf("busy[%0d]", k), busy_w[k], m_busy[k]);
        chk($sformatf("hazard_1[%0d]", k), haz1[k], m_busy[k][read_register_1]);
        chk($sformatf("hazard_2[%0d]", k), haz2[k], m_busy[k][read_register_2]);
        chk($sformatf("RegWrite[%0d]", k), rw[k], m_rw[k]);
        if (m_rw[k]) begin
          chk($sformatf("write_register[%0d]", k), wreg_w[k], m_wreg[k]);
          chk($sformatf("write_data[%0d]", k), wdata_w[k], m_wdata[k]);
        end
      end
      if (reset) begin
        m_last_was_a[k] = 0;
        m_busy[k]       = '0;
        m_rw[k]         = 0;
        m_wreg[k]       = '0;
        m_wdata[k]      = '0;
      end else begin
        m_rw[k] = 0;
        if (ta || tb) begin
          m_last_was_a[k] = ta;
          r = ta ? a_register : b_register;
          if (r != 0) begin
            m_rw[k]      = 1;
            m_wreg[k]    = r;
            m_wdata[k]   = ta ? a_data : b_data;
            m_busy[k][r] = 1'b0;
          end
        end
        if (reserve_valid && reserve_register != 0) m_busy[k][reserve_register] = 1'b1;
      end
    end
    if (reset) m_ok = 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; a_valid = 0; b_valid = 0; reserve_valid = 0;
    a_register = 0; b_register = 0; reserve_register = 0;
    a_data = 0; b_data = 0; read_register_1 = 0; read_register_2 = 0;

    // Reset held two cycles, no requests
    repeat (2) @(posedge clk);
    #1;
    chk("rst RegWrite", rw[0], 0);
    chk("rst busy", busy_w[0], 32'h0);
    chk("rst a_ready", a_rdy[0], 0);
    chk("rst b_ready", b_rdy[0], 0);
    reset = 0;

    // A alone
    a_valid = 1; a_register = 5; a_data = 32'hDEAD_BEEF;
    #1;
    chk("A only a_ready rr", a_rdy[0], 1);
    chk("A only a_ready fp", a_rdy[1], 1);
    tick();
    a_valid = 0;
    #1;
    chk("A only RegWrite", rw[0], 1);
    chk("A only write_register", wreg_w[0], 5);
    chk("A only write_data", wdata_w[0], 32'hDEAD_BEEF);
    tick();
    #1;
    chk("idle RegWrite", rw[0], 0);
    chk("idle hold write_register", wreg_w[0], 5);
    chk("idle hold write_data", wdata_w[0], 32'hDEAD_BEEF);

    // B alone, leaving B as the last winner
    b_valid = 1; b_register = 4; b_data = 32'h44;
    #1;
    chk("B only b_ready", b_rdy[0], 1);
    tick();
    b_valid = 0;

    // Contention for four cycles
    a_valid = 1; a_register = 3; a_data = 32'h33;
    b_valid = 1; b_register = 7; b_data = 32'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr grant%0d a", i), a_rdy[0], (i % 2 == 0));
      chk($sformatf("rr grant%0d b", i), b_rdy[0], (i % 2 == 1));
      chk($sformatf("fp grant%0d a", i), a_rdy[1], 1);
      chk($sformatf("fp grant%0d b", i), b_rdy[1], 0);
      tick();
    end
    a_valid = 0; b_valid = 0;
    #1;
    chk("rr last write_register", wreg_w[0], 7);
    chk("rr last write_data", wdata_w[0], 32'h77);
    chk("fp last write_register", wreg_w[1], 3);

    // Scoreboard on register 9
    reserve_valid = 1; reserve_register = 9; read_register_1 = 9; read_register_2 = 3;
    tick();
    reserve_valid = 0;
    #1;
    chk("reserve busy9", busy_w[0][9], 1);
    chk("reserve hazard_1", haz1[0], 1);
    chk("reserve hazard_2", haz2[0], 0);
    b_valid = 1; b_register = 9; b_data = 32'h99;
    tick();
    b_valid = 0;
    #1;
    chk("clear busy9", busy_w[0][9], 0);
    chk("clear hazard_1", haz1[0], 0);
    reserve_valid = 1; reserve_register = 9;
    tick();
    b_valid = 1; b_register = 9; b_data = 32'h999;
    tick();
    reserve_valid = 0; b_valid = 0;
    #1;
    chk("same-edge busy9", busy_w[0][9], 1);
    b_valid = 1;
    tick();
    b_valid = 0;

    // Register 0
    a_valid = 1; a_register = 0; a_data = 32'h1234;
    #1;
    chk("r0 a_ready", a_rdy[0], 1);
    tick();
    a_valid = 0;
    #1;
    chk("r0 RegWrite", rw[0], 0);
    reserve_valid = 1; reserve_register = 0;
    tick();
    reserve_valid = 0;
    #1;
    chk("r0 reserve busy", busy_w[0], 32'h0);

    // Reset while busy and requests pending
    for (int r = 8; r < 12; r++) begin
      reserve_valid = 1; reserve_register = r[4:0];
      tick();
    end
    reserve_valid = 0;
    #1;
    chk("pre-reset busy", busy_w[0], 32'h0000_0F00);
    a_valid = 1; a_register = 1; a_data = 32'hA1;
    b_valid = 1; b_register = 2; b_data = 32'hB2;
    reset = 1;
    tick();
    #1;
    chk("reset RegWrite", rw[0], 0);
    chk("reset busy", busy_w[0], 32'h0);
    reset = 0;
    #1;
    chk("post-reset a_ready", a_rdy[0], 1);
    chk("post-reset b_ready", b_rdy[0], 0);
    tick();
    a_valid = 0; b_valid = 0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
